// File: rtl/srl_delay_line_pkg.sv
// srl_delay_line_pkg: shared data width, SRL primitive length and clog2 helper
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package srl_delay_line_pkg;
    localparam int SRL_LEN = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/srl_bit_chain.sv
// srl_bit_chain: one bit column of cascaded 32-deep shift segments with a read tap
module srl_bit_chain import srl_delay_line_pkg::*; #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          en,
    input  logic          d,
    input  logic [AW-1:0] a,
    output logic          q
);
    localparam int NSEG = DEPTH / SRL_LEN;

    logic [DEPTH-1:0] w_all;
    logic [NSEG-1:0]  w_cin;

    assign w_cin[0] = d;

    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        logic [SRL_LEN-1:0] r_seg;
        // Q31 of the previous segment feeds this segment's D input
        if (g > 0) begin : g_casc
            assign w_cin[g] = w_all[g*SRL_LEN-1];
        end
        always_ff @(posedge clk) begin
            if (en) r_seg <= {r_seg[SRL_LEN-2:0], w_cin[g]};
        end
        assign w_all[g*SRL_LEN +: SRL_LEN] = r_seg;
    end

    assign q = w_all[a];
endmodule

// File: rtl/srl_delay_line.sv
// srl_delay_line: programmable-delay sample line; SRL storage is unreset and masked by fill
module srl_delay_line import srl_delay_line_pkg::*; #(
    parameter int WIDTH      = 2*`DATA_WIDTH,
    parameter int MAX_DEPTH  = 64,
    parameter int DEF_DLY_M1 = MAX_DEPTH-1,
    localparam int AW        = clog2(MAX_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [AW-1:0]    dly_m1,
    input  logic             dly_ld,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             dout_valid,
    output logic [WIDTH-1:0] dout
);
    logic             w_shift;
    logic             w_ready;
    logic [WIDTH-1:0] w_tap;
    logic [AW:0]      r_fill;
    logic [AW-1:0]    r_dly;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;

    assign w_shift = rst_n && ce && din_valid;
    assign w_ready = r_fill >= ({1'b0, r_dly} + 1'b1);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        srl_bit_chain #(.DEPTH(MAX_DEPTH), .AW(AW)) u_chain (
            .clk (clk),
            .en  (w_shift),
            .d   (din[b]),
            .a   (r_dly),
            .q   (w_tap[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill       <= '0;
            r_dly        <= AW'(DEF_DLY_M1);
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            // a load restarts the fill count, so pre-load data can never be flagged valid
            r_dout_valid <= w_shift && w_ready && !dly_ld;
            if (w_shift) r_dout <= w_tap;
            if (ce && dly_ld) begin
                r_dly  <= dly_m1;
                r_fill <= {AW'(0), w_shift};
            end else if (w_shift && r_fill != (AW+1)'(MAX_DEPTH)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
endmodule
